// File: rtl/branch_predict_unit_if.sv
// Lookup (IF) and update (ID) signal bundle for branch_predict_unit.
// The pipeline drives the master side and the predictor implements the slave side.
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32
);
  logic              if_valid_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [ADDR_W-1:0] upd_pred_target_i;
  logic              mispredict_o;
  logic [ADDR_W-1:0] redirect_pc_o;

  modport master (
    output if_valid_i, if_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    output upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o
  );

  modport slave (
    input  if_valid_i, if_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating-counter history for the 5-stage MIPS pipeline.
// Optional macro BPU_STATS_EN adds saturating branch / misprediction counters.
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  branch_predict_unit_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]          stat_branches_o,
  output logic [31:0]          stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int unsigned CTR_HALF = 1 << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(CTR_HALF - 1);
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(CTR_HALF);
  localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lkp_idx;
  logic [TAG_W-1:0]  lkp_tag;
  logic              lkp_hit;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;

  logic              ent_we;
  logic [ADDR_W-1:0] ent_target_d;
  logic [CTR_W-1:0]  ent_ctr_d;

  logic              unused_bits;

  assign unused_bits = ^{bus.if_valid_i, bus.if_pc_i[1:0]};

  assign lkp_idx = bus.if_pc_i[IDX_W+1:2];
  assign lkp_tag = bus.if_pc_i[ADDR_W-1:IDX_W+2];
  assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);

  assign bus.pred_taken_o  = lkp_hit && ctr_q[lkp_idx][CTR_W-1];
  assign bus.pred_target_o = lkp_hit ? target_q[lkp_idx] : '0;

  assign bus.mispredict_o = bus.upd_valid_i &&
                            ((bus.upd_pred_taken_i != bus.upd_taken_i) ||
                             (bus.upd_taken_i && (bus.upd_pred_target_i != bus.upd_target_i)));
  assign bus.redirect_pc_o = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + ADDR_W'(4);

  assign upd_idx = bus.upd_pc_i[IDX_W+1:2];
  assign upd_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // A not-taken branch that misses is never allocated, so cold not-taken code leaves the table alone.
  always_comb begin
    ent_we       = 1'b0;
    ent_target_d = target_q[upd_idx];
    ent_ctr_d    = ctr_q[upd_idx];
    if (bus.upd_valid_i) begin
      if (upd_hit) begin
        ent_we = 1'b1;
        if (bus.upd_taken_i) begin
          ent_target_d = bus.upd_target_i;
          if (ctr_q[upd_idx] != CTR_MAX) ent_ctr_d = ctr_q[upd_idx] + CTR_W'(1);
        end else if (ctr_q[upd_idx] != '0) begin
          ent_ctr_d = ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (bus.upd_taken_i) begin
        ent_we       = 1'b1;
        ent_target_d = bus.upd_target_i;
        ent_ctr_d    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else if (ent_we) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= ent_target_d;
      ctr_q[upd_idx]    <= ent_ctr_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q,  stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (bus.upd_valid_i && (stat_branches_q != 32'hFFFF_FFFF)) stat_branches_d = stat_branches_q + 32'd1;
    if (bus.mispredict_o && (stat_mispred_q != 32'hFFFF_FFFF)) stat_mispred_d = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus pushes expectations from a table-level
// reference model, a negedge monitor pops and compares. Stats are checked when BPU_STATS_EN is set.
module tb_branch_predict_unit;

  localparam int ENTRIES  = 16;
  localparam int CTR_W    = 2;
  localparam int ADDR_W   = 32;
  localparam int IDX_W    = $clog2(ENTRIES);
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);

  typedef struct packed {
    logic        predTaken;
    logic [31:0] predTarget;
    logic        mispredict;
    logic [31:0] redirect;
    logic [31:0] branches;
    logic [31:0] mispred;
  } expT;

  logic clk;
  logic rst_n;

  branch_predict_unit_if #(.ADDR_W(ADDR_W)) bus();

`ifdef BPU_STATS_EN
  logic [31:0] statBranches;
  logic [31:0] statMispred;
`endif

  branch_predict_unit #(
    .ENTRIES(ENTRIES),
    .CTR_W  (CTR_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
`ifdef BPU_STATS_EN
    ,
    .stat_branches_o(statBranches),
    .stat_mispred_o (statMispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          mValid  [ENTRIES];
  logic [31:0] mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  logic [31:0] expBranches;
  logic [31:0] expMispred;

  expT   expQ[$];
  string nameQ[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic int idxOf(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tagOf(logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
  endfunction

  function automatic bit modelTaken(logic [31:0] pc);
    return modelHit(pc) && (mCtr[idxOf(pc)] >= CTR_HALF);
  endfunction

  function automatic logic [31:0] modelTarget(logic [31:0] pc);
    return modelHit(pc) ? mTarget[idxOf(pc)] : 32'd0;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i]  = 1'b0;
      mTag[i]    = 32'd0;
      mTarget[i] = 32'd0;
      mCtr[i]    = CTR_HALF - 1;
    end
    expBranches = 32'd0;
    expMispred  = 32'd0;
  endtask

  task automatic modelUpdate(logic [31:0] pc, bit taken, logic [31:0] target);
    int i;
    i = idxOf(pc);
    if (modelHit(pc)) begin
      if (taken) begin
        mCtr[i]    = (mCtr[i] < CTR_MAX) ? mCtr[i] + 1 : CTR_MAX;
        mTarget[i] = target;
      end else begin
        mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
      end
    end else if (taken) begin
      mValid[i]  = 1'b1;
      mTag[i]    = tagOf(pc);
      mTarget[i] = target;
      mCtr[i]    = CTR_HALF;
    end
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] r;
    if ($urandom_range(0, 9) == 0) r = 32'hFFFF_FFFC;
    else r = 32'(($urandom_range(0, 3) << (2 + IDX_W)) | ($urandom_range(0, ENTRIES - 1) << 2));
    r[1:0] = 2'($urandom_range(0, 3));
    return r;
  endfunction

  // One cycle of stimulus: expectation is taken from the model before this cycle's update lands.
  task automatic applyStimulus(string name, bit rstLow, logic [31:0] ifPc, bit updValid,
                               logic [31:0] updPc, bit updTaken, logic [31:0] updTarget,
                               bit updPredTaken, logic [31:0] updPredTarget);
    expT e;
    bit  mis;
    rst_n                 = !rstLow;
    bus.if_valid_i        = 1'b1;
    bus.if_pc_i           = ifPc;
    bus.upd_valid_i       = updValid;
    bus.upd_pc_i          = updPc;
    bus.upd_taken_i       = updTaken;
    bus.upd_target_i      = updTarget;
    bus.upd_pred_taken_i  = updPredTaken;
    bus.upd_pred_target_i = updPredTarget;
    if (rstLow) clearModel();
    mis = updValid && ((updPredTaken != updTaken) || (updTaken && (updPredTarget != updTarget)));
    e.predTaken  = modelTaken(ifPc);
    e.predTarget = modelTarget(ifPc);
    e.mispredict = mis;
    e.redirect   = updTaken ? updTarget : updPc + 32'd4;
    e.branches   = expBranches;
    e.mispred    = expMispred;
    expQ.push_back(e);
    nameQ.push_back(name);
    if (!rstLow) begin
      if (updValid) modelUpdate(updPc, updTaken, updTarget);
      if (updValid && (expBranches != 32'hFFFF_FFFF)) expBranches = expBranches + 32'd1;
      if (mis && (expMispred != 32'hFFFF_FFFF)) expMispred = expMispred + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(string name, logic [31:0] pc);
    applyStimulus(name, 1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    expT   e;
    string n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput({n, ".predTaken"},  32'(bus.pred_taken_o), 32'(e.predTaken));
        checkOutput({n, ".predTarget"}, bus.pred_target_o,     e.predTarget);
        checkOutput({n, ".mispredict"}, 32'(bus.mispredict_o), 32'(e.mispredict));
        checkOutput({n, ".redirect"},   bus.redirect_pc_o,     e.redirect);
`ifdef BPU_STATS_EN
        checkOutput({n, ".statBranches"}, statBranches, e.branches);
        checkOutput({n, ".statMispred"},  statMispred,  e.mispred);
`endif
      end
    end
  end

  initial begin
    logic [31:0] pc, tgt, ptgt;
    bit          tk, ptk;
    int          drain;
    rst_n = 1'b0;
    bus.if_valid_i = 1'b0;  bus.if_pc_i = '0;
    bus.upd_valid_i = 1'b0; bus.upd_pc_i = '0; bus.upd_taken_i = 1'b0; bus.upd_target_i = '0;
    bus.upd_pred_taken_i = 1'b0; bus.upd_pred_target_i = '0;
    clearModel();
    @(posedge clk);
    #1;

    applyStimulus("resetLookup", 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    lookup("coldLookup", 32'h40);
    applyStimulus("allocTaken", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'd0);
    lookup("afterAlloc", 32'h40);
    applyStimulus("ntMispred", 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1, 32'h80);
    lookup("weakNt", 32'h40);
    applyStimulus("nt2", 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus("nt3Sat", 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);
    lookup("strongNt", 32'h40);
    applyStimulus("aliasEvict", 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'd0);
    lookup("aliasOldMiss", 32'h40);
    lookup("aliasNewHit", 32'h80);
    applyStimulus("sameCycle", 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h200);
    applyStimulus("targetMiss", 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'h80);
    lookup("newTarget", 32'h80);
    applyStimulus("satTaken", 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'h90);
    applyStimulus("wrapPc", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0);

    for (int k = 0; k < 300; k++) begin
      pc  = randPc();
      tk  = 1'($urandom_range(0, 1));
      tgt = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ptk  = modelTaken(pc);
        ptgt = modelTarget(pc);
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
      end
      applyStimulus("rand", 1'b0, randPc(), 1'($urandom_range(0, 3) != 0), pc, tk, tgt, ptk, ptgt);
    end

    applyStimulus("preReset", 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'd0);
    applyStimulus("midReset", 1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 32'h300, 1'b1, 32'h300);
    lookup("postReset", 32'h40);

    for (int k = 0; k < 60; k++) begin
      pc  = randPc();
      tgt = $urandom;
      applyStimulus("rand2", 1'b0, randPc(), 1'b1, pc, 1'($urandom_range(0, 1)), tgt,
                    modelTaken(pc), modelTarget(pc));
    end

    drain = 0;
    while ((expQ.size() != 0) && (drain < 10)) begin
      @(posedge clk);
      drain++;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
